// File: rtl/cache_maint_ctrl.sv
// rtl/cache_maint_ctrl.sv - CP15 c7 cache-maintenance sequencer (I-flash, D set/way scan, writeback)
//
// Purpose: turns one-cycle INVI/INVD/CleanI/CleanD pulses into a full maintenance
// pass: optional I-cache flash invalidate, then a set/way walk of the D-cache
// that writes back dirty lines (clean) and/or invalidates lines (inv).
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   INVI, INVD, CleanI, CleanD    maintenance request pulses
//   LineValid, LineDirty          status of line {MaintSet, MaintWay}, same cycle
//   WBAck                         memory accepted the current writeback
//   StallMaint                    pipeline stall while maintenance is active
//   MaintSet, MaintWay            line currently addressed
//   WBReq                         writeback request, held until WBAck
//   DClearDirty, DInvLine         clear dirty bit / invalidate current D line
//   IInvAll                       flash-invalidate the I-cache
//   Done                          one-cycle completion pulse
//   MaintWBCount                  accepted-writeback count
//
// Optional feature: CACHE_MAINT_STATS_EN enables the saturating writeback
// counter on MaintWBCount; otherwise MaintWBCount is tied to 0.

module cache_maint_ctrl #(
   parameter int SET_BITS = 6,
   parameter int WAYS     = 2,
   localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                INVI,
   input  logic                INVD,
   input  logic                CleanI,
   input  logic                CleanD,
   input  logic                LineValid,
   input  logic                LineDirty,
   input  logic                WBAck,
   output logic                StallMaint,
   output logic [SET_BITS-1:0] MaintSet,
   output logic [WAY_BITS-1:0] MaintWay,
   output logic                WBReq,
   output logic                DClearDirty,
   output logic                DInvLine,
   output logic                IInvAll,
   output logic                Done,
   output logic [15:0]         MaintWBCount
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ICLR,
      ST_SCAN,
      ST_WBWAIT,
      ST_DONE
   } state_t;

   localparam logic [SET_BITS-1:0] LAST_SET = '1;
   localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(WAYS - 1);

   state_t              r_state;
   state_t              w_next_state;
   logic [SET_BITS-1:0] r_set;
   logic [WAY_BITS-1:0] r_way;
   logic                r_inv_i;
   logic                r_inv_d;
   logic                r_clean_d;
   logic                r_pend_inv_i;
   logic                r_pend_inv_d;
   logic                r_pend_clean_d;
   logic                r_pend_any;

   logic w_pulse;
   logic w_req;
   logic w_new_inv_i;
   logic w_new_inv_d;
   logic w_new_clean_d;
   logic w_last;
   logic w_load;
   logic w_advance;

   assign w_pulse       = INVI | INVD | CleanI | CleanD;
   // r_pend_any also covers a deferred CleanI, which has no flag of its own.
   assign w_req         = w_pulse | r_pend_any;
   assign w_new_inv_i   = INVI   | r_pend_inv_i;
   assign w_new_inv_d   = INVD   | r_pend_inv_d;
   assign w_new_clean_d = CleanD | r_pend_clean_d;
   assign w_last        = (r_set == LAST_SET) && (r_way == LAST_WAY);

   // A deferred request waiting in IDLE is itself a request cycle, so the stall
   // stays up across back-to-back passes.
   assign StallMaint = (r_state != ST_IDLE) | w_pulse | r_pend_any;
   assign MaintSet   = r_set;
   assign MaintWay   = r_way;

   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_advance    = 1'b0;
      WBReq        = 1'b0;
      DClearDirty  = 1'b0;
      DInvLine     = 1'b0;
      IInvAll      = 1'b0;
      Done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               w_load = 1'b1;
               if (w_new_inv_i)
                  w_next_state = ST_ICLR;
               else if (w_new_inv_d | w_new_clean_d)
                  w_next_state = ST_SCAN;
               else
                  w_next_state = ST_DONE;
            end
         end
         ST_ICLR: begin
            IInvAll      = 1'b1;
            w_next_state = (r_inv_d | r_clean_d) ? ST_SCAN : ST_DONE;
         end
         ST_SCAN: begin
            if (r_clean_d & LineValid & LineDirty) begin
               WBReq        = 1'b1;
               w_next_state = ST_WBWAIT;
            end else begin
               DInvLine     = r_inv_d;
               w_advance    = 1'b1;
               w_next_state = w_last ? ST_DONE : ST_SCAN;
            end
         end
         ST_WBWAIT: begin
            WBReq = 1'b1;
            if (WBAck) begin
               DClearDirty  = 1'b1;
               DInvLine     = r_inv_d;
               w_advance    = 1'b1;
               w_next_state = w_last ? ST_DONE : ST_SCAN;
            end
         end
         ST_DONE: begin
            Done         = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_set          <= '0;
         r_way          <= '0;
         r_inv_i        <= 1'b0;
         r_inv_d        <= 1'b0;
         r_clean_d      <= 1'b0;
         r_pend_inv_i   <= 1'b0;
         r_pend_inv_d   <= 1'b0;
         r_pend_clean_d <= 1'b0;
         r_pend_any     <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_load) begin
            r_inv_i        <= w_new_inv_i;
            r_inv_d        <= w_new_inv_d;
            r_clean_d      <= w_new_clean_d;
            r_pend_inv_i   <= 1'b0;
            r_pend_inv_d   <= 1'b0;
            r_pend_clean_d <= 1'b0;
            r_pend_any     <= 1'b0;
            r_set          <= '0;
            r_way          <= '0;
         end else begin
            if (r_state != ST_IDLE) begin
               r_pend_inv_i   <= r_pend_inv_i   | INVI;
               r_pend_inv_d   <= r_pend_inv_d   | INVD;
               r_pend_clean_d <= r_pend_clean_d | CleanD;
               r_pend_any     <= r_pend_any     | w_pulse;
            end
            // Way first, then set; the set counter wraps naturally after the
            // last line, leaving the index at (0,0) for the next pass.
            if (w_advance) begin
               if (r_way == LAST_WAY) begin
                  r_way <= '0;
                  r_set <= r_set + SET_BITS'(1);
               end else begin
                  r_way <= r_way + WAY_BITS'(1);
               end
            end
         end
      end
   end

`ifdef CACHE_MAINT_STATS_EN
   logic        w_ack;
   logic [15:0] r_wb_count;

   assign w_ack = (r_state == ST_WBWAIT) & WBAck;

   always_ff @(posedge clk) begin
      if (reset)
         r_wb_count <= 16'd0;
      else if (w_ack && (r_wb_count != 16'hFFFF))
         r_wb_count <= r_wb_count + 16'd1;
   end

   assign MaintWBCount = r_wb_count;
`else
   assign MaintWBCount = 16'd0;
`endif

endmodule

// File: tb/tb_cache_maint_ctrl.sv
// tb/tb_cache_maint_ctrl.sv - directed self-checking bench for cache_maint_ctrl (SET_BITS=2, WAYS=2)

module tb_cache_maint_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        INVI, INVD, CleanI, CleanD;
   logic        LineValid, LineDirty;
   logic        WBAck;
   logic        StallMaint;
   logic [1:0]  MaintSet;
   logic [0:0]  MaintWay;
   logic        WBReq, DClearDirty, DInvLine, IInvAll, Done;
   logic [15:0] MaintWBCount;

   logic [7:0]  r_valid;
   logic [7:0]  r_dirty;
   logic [2:0]  w_idx;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   logic [15:0] exp_cnt1;
   logic [15:0] exp_cnt2;

   cache_maint_ctrl #(.SET_BITS(2), .WAYS(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .INVI         (INVI),
      .INVD         (INVD),
      .CleanI       (CleanI),
      .CleanD       (CleanD),
      .LineValid    (LineValid),
      .LineDirty    (LineDirty),
      .WBAck        (WBAck),
      .StallMaint   (StallMaint),
      .MaintSet     (MaintSet),
      .MaintWay     (MaintWay),
      .WBReq        (WBReq),
      .DClearDirty  (DClearDirty),
      .DInvLine     (DInvLine),
      .IInvAll      (IInvAll),
      .Done         (Done),
      .MaintWBCount (MaintWBCount)
   );

   always #5 clk = ~clk;

   assign w_idx     = {MaintSet, MaintWay};
   assign LineValid = r_valid[w_idx];
   assign LineDirty = r_dirty[w_idx];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle; inputs are driven 2 time units after the edge
   // and outputs are sampled a further unit later, well away from either edge.
   task automatic tick();
      @(posedge clk);
      #2;
      INVI = 1'b0; INVD = 1'b0; CleanI = 1'b0; CleanD = 1'b0; WBAck = 1'b0;
   endtask

   task automatic chk_line(input string tag, input int idx, input logic inv, input logic wb);
      chk({tag, "_set"}, MaintSet, idx / 2);
      chk({tag, "_way"}, MaintWay, idx % 2);
      chk({tag, "_dinv"}, DInvLine, inv);
      chk({tag, "_wbreq"}, WBReq, wb);
   endtask

   initial begin
`ifdef CACHE_MAINT_STATS_EN
      exp_cnt1 = 16'd1;
      exp_cnt2 = 16'd2;
`else
      exp_cnt1 = 16'd0;
      exp_cnt2 = 16'd0;
`endif
      reset = 1'b1;
      INVI = 1'b0; INVD = 1'b0; CleanI = 1'b0; CleanD = 1'b0; WBAck = 1'b0;
      r_valid = 8'hFF;
      r_dirty = 8'h00;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_stall", StallMaint, 0);
      chk("rst_set", MaintSet, 0);
      chk("rst_way", MaintWay, 0);
      chk("rst_outs", {WBReq, DClearDirty, DInvLine, IInvAll, Done}, 0);
      chk("rst_cnt", MaintWBCount, 0);

      // Stray ack in IDLE must do nothing
      tick(); WBAck = 1'b1; #1;
      chk("idle_ack_outs", {StallMaint, WBReq, DClearDirty, DInvLine}, 0);

      // INVI only
      tick(); INVI = 1'b1; #1;
      chk("invi_c0_stall", StallMaint, 1);
      chk("invi_c0_iinv", IInvAll, 0);
      tick(); #1;
      chk("invi_c1_stall", StallMaint, 1);
      chk("invi_c1_iinv", IInvAll, 1);
      chk("invi_c1_done", Done, 0);
      tick(); #1;
      chk("invi_c2_stall", StallMaint, 1);
      chk("invi_c2_iinv", IInvAll, 0);
      chk("invi_c2_done", Done, 1);
      tick(); #1;
      chk("invi_c3_stall", StallMaint, 0);
      chk("invi_c3_done", Done, 0);
      chk("invi_c3_cnt", MaintWBCount, 0);

      // INVD, all valid and clean
      tick(); INVD = 1'b1; #1;
      chk("invd_c0_stall", StallMaint, 1);
      for (int i = 0; i < 8; i++) begin
         tick(); #1;
         chk_line($sformatf("invd_l%0d", i), i, 1'b1, 1'b0);
      end
      tick(); #1;
      chk("invd_done", Done, 1);
      chk("invd_done_dinv", DInvLine, 0);
      tick(); #1;
      chk("invd_idle_stall", StallMaint, 0);

      // CleanD, only line (1,1) dirty, ack three cycles after WBReq rises
      r_dirty = 8'b0000_1000;
      tick(); CleanD = 1'b1; #1;
      chk("cln_c0_stall", StallMaint, 1);
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk_line($sformatf("cln_l%0d", i), i, 1'b0, 1'b0);
      end
      tick(); #1;
      chk_line("cln_wbrise", 3, 1'b0, 1'b1);
      tick(); #1;
      chk_line("cln_hold1", 3, 1'b0, 1'b1);
      chk("cln_hold1_clr", DClearDirty, 0);
      tick(); #1;
      chk_line("cln_hold2", 3, 1'b0, 1'b1);
      tick(); WBAck = 1'b1; #1;
      chk_line("cln_ack", 3, 1'b0, 1'b1);
      chk("cln_ack_clr", DClearDirty, 1);
      r_dirty = 8'h00;
      for (int i = 4; i < 8; i++) begin
         tick(); #1;
         chk_line($sformatf("cln_l%0d", i), i, 1'b0, 1'b0);
         chk($sformatf("cln_l%0d_clr", i), DClearDirty, 0);
      end
      tick(); #1;
      chk("cln_done", Done, 1);
      chk("cln_cnt", MaintWBCount, exp_cnt1);
      tick(); #1;
      chk("cln_idle_stall", StallMaint, 0);

      // CleanD + INVD, line (0,0) dirty, immediate ack
      r_dirty = 8'b0000_0001;
      tick(); CleanD = 1'b1; INVD = 1'b1; #1;
      chk("ci_c0_stall", StallMaint, 1);
      tick(); #1;
      chk_line("ci_wbrise", 0, 1'b0, 1'b1);
      tick(); WBAck = 1'b1; #1;
      chk_line("ci_ack", 0, 1'b1, 1'b1);
      chk("ci_ack_clr", DClearDirty, 1);
      r_dirty = 8'h00;
      for (int i = 1; i < 8; i++) begin
         tick(); #1;
         chk_line($sformatf("ci_l%0d", i), i, 1'b1, 1'b0);
      end
      tick(); #1;
      chk("ci_done", Done, 1);
      chk("ci_cnt", MaintWBCount, exp_cnt2);
      tick(); #1;
      chk("ci_idle_stall", StallMaint, 0);

      // Reset during WBWAIT
      r_dirty = 8'b0000_0001;
      tick(); CleanD = 1'b1; #1;
      tick(); #1;
      chk("rw_wbrise", WBReq, 1);
      tick(); reset = 1'b1; #1;
      chk("rw_wbwait", WBReq, 1);
      tick(); reset = 1'b0; #1;
      chk("rw_after_wbreq", WBReq, 0);
      chk("rw_after_stall", StallMaint, 0);
      chk("rw_after_set", MaintSet, 0);
      chk("rw_after_way", MaintWay, 0);
      chk("rw_after_cnt", MaintWBCount, 0);
      tick(); WBAck = 1'b1; #1;
      chk("rw_lateack_outs", {StallMaint, WBReq, DClearDirty, DInvLine, Done}, 0);
      tick(); #1;
      chk("rw_lateack_cnt", MaintWBCount, 0);
      chk("rw_lateack_stall", StallMaint, 0);
      r_dirty = 8'h00;

      // INVD arriving during a CleanD scan triggers a second full pass
      tick(); CleanD = 1'b1; #1;
      chk("pend_c0_stall", StallMaint, 1);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 2) INVD = 1'b1;
         #1;
         chk_line($sformatf("pend_a_l%0d", i), i, 1'b0, 1'b0);
         chk($sformatf("pend_a_l%0d_stall", i), StallMaint, 1);
      end
      tick(); #1;
      chk("pend_a_done", Done, 1);
      chk("pend_a_done_stall", StallMaint, 1);
      tick(); #1;
      chk("pend_gap_stall", StallMaint, 1);
      chk("pend_gap_done", Done, 0);
      for (int i = 0; i < 8; i++) begin
         tick(); #1;
         chk_line($sformatf("pend_b_l%0d", i), i, 1'b1, 1'b0);
         chk($sformatf("pend_b_l%0d_stall", i), StallMaint, 1);
      end
      tick(); #1;
      chk("pend_b_done", Done, 1);
      tick(); #1;
      chk("pend_end_stall", StallMaint, 0);
      chk("pend_end_done", Done, 0);

      // CleanI alone: straight to DONE
      tick(); CleanI = 1'b1; #1;
      chk("cli_c0_stall", StallMaint, 1);
      tick(); #1;
      chk("cli_c1_done", Done, 1);
      chk("cli_c1_iinv", IInvAll, 0);
      tick(); #1;
      chk("cli_c2_stall", StallMaint, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
